// File: rtl/colourflash_seq.sv
// colourflash_seq: flashes the first `round` colours of `segment`, then checks one press/release per step.
// Outputs are registered one cycle behind the FSM; no backpressure. COLOURFLASH_TIMEOUT_EN adds an idle-input timeout in WAIT_IN.
module colourflash_seq #(
   parameter int NUM_COLOURS    = 4,
   parameter int SEQ_DEPTH      = 32,
   parameter int ON_CYCLES      = 2,
   parameter int OFF_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int IDX_W   = (NUM_COLOURS > 2) ? $clog2(NUM_COLOURS) : 1,
   localparam int ROUND_W = $clog2(SEQ_DEPTH + 1)
) (
   input  logic                            flash_clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [ROUND_W-1:0]              round,
   input  logic [SEQ_DEPTH-1:0][IDX_W-1:0] segment,
   input  logic [NUM_COLOURS-1:0]          player_input,
   output logic [NUM_COLOURS-1:0]          disp,
   output logic                            busy,
   output logic                            await_input,
   output logic                            round_pass,
   output logic                            round_fail
);

   localparam int STEP_W    = (SEQ_DEPTH > 2) ? $clog2(SEQ_DEPTH) : 1;
   localparam int PHASE_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

   localparam logic [CNT_W-1:0]   ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0]   OFF_LAST = CNT_W'(OFF_CYCLES - 1);
   localparam logic [ROUND_W-1:0] DEPTH_R  = ROUND_W'(SEQ_DEPTH);
   localparam logic [IDX_W:0]     NUM_C    = (IDX_W + 1)'(NUM_COLOURS);

   typedef enum logic [2:0] {
      IDLE, FLASH_ON, FLASH_OFF, WAIT_IN, HOLD, PASS, FAIL
   } state_t;

   state_t               state_q, state_d;
   logic [STEP_W-1:0]    idx_q, idx_d;
   logic [ROUND_W-1:0]   round_q, round_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ROUND_W-1:0]   idx_inc;
   logic [NUM_COLOURS-1:0] want;
   logic                 multi;

   logic [NUM_COLOURS-1:0] disp_d;
   logic                   busy_d, await_d, pass_d, fail_d;

   // Out-of-range colour indices light nothing and can never be matched.
   function automatic logic [NUM_COLOURS-1:0] colour_mask(input logic [IDX_W-1:0] c);
      if ({1'b0, c} < NUM_C) return NUM_COLOURS'(1) << c;
      return '0;
   endfunction

   assign idx_inc = ROUND_W'(idx_q) + 1'b1;
   assign want    = colour_mask(segment[idx_q]);
   assign multi   = |(player_input & (player_input - 1'b1));

`ifdef COLOURFLASH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] tmo_q, tmo_d;

   always_ff @(posedge flash_clk) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`endif

   always_ff @(posedge flash_clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         round_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         round_q <= round_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      round_d = round_q;
      cnt_d   = cnt_q;
`ifdef COLOURFLASH_TIMEOUT_EN
      // Cleared everywhere except while idling in WAIT_IN, so it restarts on every entry.
      tmo_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               round_d = (round > DEPTH_R) ? DEPTH_R : round;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = (round == '0) ? PASS : FLASH_ON;
            end
         end
         FLASH_ON: begin
            if (cnt_q == ON_LAST) begin
               cnt_d   = '0;
               state_d = FLASH_OFF;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FLASH_OFF: begin
            if (cnt_q == OFF_LAST) begin
               cnt_d = '0;
               if (idx_inc < round_q) begin
                  idx_d   = idx_q + 1'b1;
                  state_d = FLASH_ON;
               end else begin
                  idx_d   = '0;
                  state_d = WAIT_IN;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_IN: begin
            if (player_input != '0) begin
               state_d = (multi || player_input != want) ? FAIL : HOLD;
            end else begin
`ifdef COLOURFLASH_TIMEOUT_EN
               if (tmo_q == TO_LAST) state_d = FAIL;
               else                  tmo_d   = tmo_q + 1'b1;
`endif
            end
         end
         HOLD: begin
            if (player_input == '0) begin
               if (idx_inc == round_q) begin
                  state_d = PASS;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = WAIT_IN;
               end
            end
         end
         PASS:    state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      disp_d  = '0;
      busy_d  = (state_q != IDLE);
      await_d = (state_q == WAIT_IN) || (state_q == HOLD);
      pass_d  = (state_q == PASS);
      fail_d  = (state_q == FAIL);
      case (state_q)
         FLASH_ON: disp_d = want;
         HOLD:     disp_d = player_input;
         default:  disp_d = '0;
      endcase
   end

   always_ff @(posedge flash_clk) begin
      if (reset) begin
         disp        <= '0;
         busy        <= 1'b0;
         await_input <= 1'b0;
         round_pass  <= 1'b0;
         round_fail  <= 1'b0;
      end else begin
         disp        <= disp_d;
         busy        <= busy_d;
         await_input <= await_d;
         round_pass  <= pass_d;
         round_fail  <= fail_d;
      end
   end

endmodule

// File: tb/tb_colourflash_seq.sv
// Directed bench for colourflash_seq: per-cycle check against a schedule-based model plus hand-computed literal checks.
module tb_colourflash_seq;

   localparam int NC  = 4;
   localparam int SD  = 32;
   localparam int ON  = 2;
   localparam int OFF = 1;
   localparam int P   = ON + OFF;
   localparam int TMO = 64;
   localparam int RW  = 6;

   logic                 flash_clk;
   logic                 reset;
   logic                 start;
   logic [RW-1:0]        round;
   logic [SD-1:0][1:0]   segment;
   logic [NC-1:0]        pin;
   logic [NC-1:0]        disp;
   logic                 busy, await_input, round_pass, round_fail;

   colourflash_seq dut (
      .flash_clk    (flash_clk),
      .reset        (reset),
      .start        (start),
      .round        (round),
      .segment      (segment),
      .player_input (pin),
      .disp         (disp),
      .busy         (busy),
      .await_input  (await_input),
      .round_pass   (round_pass),
      .round_fail   (round_fail)
   );

   initial begin
      flash_clk = 1'b0;
      forever #5 flash_clk = ~flash_clk;
   end

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, want);
   endtask

   // ---------------- model: flash schedule by arithmetic, response by step tracking
   typedef enum {M_IDLE, M_PLAY, M_RESP, M_DONE} mphase_t;
   mphase_t ph = M_IDLE;
   int  edge_no = 0;
   int  m_start, m_rnd, m_step, m_wait;
   bit  m_hold, m_pass;
   logic [NC-1:0] e_disp;
   logic e_busy, e_await, e_pass, e_fail;

   function automatic logic [NC-1:0] onehot(input int c);
      return (c < NC) ? NC'(1 << c) : '0;
   endfunction

   task automatic model_step();
      int t;
      edge_no++;
      if (reset) begin
         e_disp = '0; e_busy = 0; e_await = 0; e_pass = 0; e_fail = 0;
         ph = M_IDLE;
         return;
      end
      // What is visible after this edge reflects the activity during the cycle before it.
      e_busy  = (ph != M_IDLE);
      e_await = (ph == M_RESP);
      e_pass  = (ph == M_DONE) && m_pass;
      e_fail  = (ph == M_DONE) && !m_pass;
      e_disp  = '0;
      if (ph == M_PLAY) begin
         t = edge_no - m_start - 1;
         if (t % P < ON) e_disp = onehot(int'(segment[t / P]));
      end
      if (ph == M_RESP && m_hold) e_disp = pin;
      case (ph)
         M_IDLE: if (start) begin
            m_start = edge_no;
            m_rnd   = (int'(round) > SD) ? SD : int'(round);
            if (m_rnd == 0) begin ph = M_DONE; m_pass = 1; end
            else ph = M_PLAY;
         end
         M_PLAY: if (edge_no == m_start + m_rnd * P) begin
            ph = M_RESP; m_step = 0; m_hold = 0; m_wait = 0;
         end
         M_RESP: begin
            if (!m_hold) begin
               if (pin != 0) begin
                  if ($countones(pin) != 1 || pin != onehot(int'(segment[m_step]))) begin
                     ph = M_DONE; m_pass = 0;
                  end else m_hold = 1;
               end else begin
`ifdef COLOURFLASH_TIMEOUT_EN
                  m_wait++;
                  if (m_wait == TMO) begin ph = M_DONE; m_pass = 0; end
`endif
               end
            end else if (pin == 0) begin
               if (m_step + 1 == m_rnd) begin ph = M_DONE; m_pass = 1; end
               else begin m_step++; m_hold = 0; m_wait = 0; end
            end
         end
         M_DONE: ph = M_IDLE;
         default: ph = M_IDLE;
      endcase
   endtask

   initial forever begin
      @(posedge flash_clk);
      model_step();
   end

   initial forever begin
      @(negedge flash_clk);
      if (cmp_en)
         chk("cycle", {24'b0, disp, busy, await_input, round_pass, round_fail},
                      {24'b0, e_disp, e_busy, e_await, e_pass, e_fail});
   end

   // ---------------- stimulus
   task automatic tick(input int n);
      repeat (n) @(negedge flash_clk);
   endtask

   task automatic start_round(input int r);
      round = RW'(r);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic press(input logic [NC-1:0] v);
      pin = v;
      tick(2);
      chk("hold_echo", 32'(disp), 32'(v));
      tick(1);
      pin = '0;
      tick(1);
   endtask

   logic [NC-1:0] flash3 [9] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001,
                                 4'b0000, 4'b1000, 4'b1000, 4'b0000};

   initial begin
      int lits;
      logic [NC-1:0] prev;
      reset = 1'b1; start = 1'b0; round = '0; pin = '0;
      for (int i = 0; i < SD; i++) segment[i] = 2'(i % 4);
      segment[0] = 2'd2; segment[1] = 2'd0; segment[2] = 2'd3;
      tick(2);
      reset  = 1'b0;
      cmp_en = 1'b1;
      tick(1);
      chk("reset_outputs", {24'b0, disp, busy, await_input, round_pass, round_fail}, 32'h0);

      // full correct round of 3
      start_round(3);
      for (int i = 0; i < 9; i++) begin
         tick(1);
         chk("flash3_disp", 32'(disp), 32'(flash3[i]));
         chk("flash3_await_low", 32'(await_input), 32'h0);
      end
      tick(1);
      chk("await_rise_k10", 32'(await_input), 32'h1);
      press(4'b0100); press(4'b0001); press(4'b1000);
      chk("pass_not_yet", 32'(round_pass), 32'h0);
      tick(1);
      chk("pass_pulse", 32'(round_pass), 32'h1);
      chk("pass_busy", 32'(busy), 32'h1);
      tick(1);
      chk("pass_end", 32'(round_pass), 32'h0);
      chk("busy_fall", 32'(busy), 32'h0);

      // wrong second press
      start_round(3);
      tick(10);
      press(4'b0100);
      pin = 4'b0010;
      tick(1);
      pin = '0;
      chk("fail_not_yet", 32'(round_fail), 32'h0);
      tick(1);
      chk("fail_pulse", 32'(round_fail), 32'h1);
      tick(1);
      chk("fail_end", {29'b0, round_fail, busy, await_input}, 32'h0);

      // multi-press on first step
      start_round(3);
      tick(10);
      pin = 4'b0101;
      tick(1);
      pin = '0;
      tick(1);
      chk("multi_fail", 32'(round_fail), 32'h1);
      tick(1);

      // start during FLASH_ON of a round=2 run is ignored
      start_round(2);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("restart_ignored_disp", 32'(disp), 32'(flash3[i]));
         if (i == 0) begin start = 1'b1; round = RW'(3); end
         if (i == 1) start = 1'b0;
      end
      tick(1);
      chk("round2_await", 32'(await_input), 32'h1);
      press(4'b0100); press(4'b0001);
      tick(1);
      chk("round2_pass", 32'(round_pass), 32'h1);
      tick(1);

      // round 0 passes immediately
      start_round(0);
      tick(1);
      chk("round0_pass", {27'b0, disp, round_pass}, 32'h1);
      tick(1);
      chk("round0_end", 32'(round_pass), 32'h0);

      // round 40 clamps to 32 steps
      start_round(40);
      lits = 0; prev = '0;
      for (int i = 0; i < 96; i++) begin
         tick(1);
         if (disp != '0 && prev == '0) lits++;
         prev = disp;
      end
      chk("clamp_await_low", 32'(await_input), 32'h0);
      tick(1);
      chk("clamp_await_rise", 32'(await_input), 32'h1);
      chk("clamp_steps", 32'(lits), 32'd32);
      reset = 1'b1; tick(1); reset = 1'b0;

      // reset mid-FLASH_ON
      start_round(3);
      tick(1);
      chk("midflash_lit", 32'(disp), 32'h4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("reset_midflash", {27'b0, disp, busy}, 32'h0);
      start_round(1);
      tick(1);
      chk("after_reset_start", 32'(disp), 32'h4);
`ifdef COLOURFLASH_TIMEOUT_EN
      tick(66);
      chk("timeout_not_yet", 32'(round_fail), 32'h0);
      tick(1);
      chk("timeout_fail", 32'(round_fail), 32'h1);
      tick(2);
`else
      tick(100);
      chk("no_timeout", {30'b0, await_input, round_fail}, 32'h2);
      reset = 1'b1; tick(1); reset = 1'b0;
      tick(2);
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
